core_top: RTL and testbench

Single-cycle RV32I processor core with private instruction and data memories. It executes one instruction per clock from word-addressed instruction memory and accesses a separate word-addressed data memory. Both memories are preloaded hierarchically by the bench. The block is the top of the CPU subsystem and has no external data ports; its results are observed through its internal memories and register file.

---
 rtl/core_top.sv | 267 ++++++++++++++++++++++++++
 tb/tb_core_top.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_top.sv
// rtl/core_top.sv - single-cycle RV32I core with private instruction and data memories
// Optional build macro CORE_TRACE_EN adds a per-retire $display trace.

module core_imem #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:WORDS-1];

  assign rdata = mem[addr];
endmodule

module core_dmem #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  // Deliberately never reset: contents preloaded before reset must survive it.
  logic [31:0] mem [0:WORDS-1];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end
endmodule

module core_regfile (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);
  logic [31:0] regs [0:31];

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end
endmodule

module core_top #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input logic clk,
  input logic reset
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic [31:0] pc;
  logic        halted;

  assign pc     = pc_q;
  assign halted = halted_q;

  logic [31:0] instr, rs1_val, rs2_val, dm_rdata, dm_addr;
  logic [31:0] rf_wdata, dm_wdata;
  logic        rf_we, dm_we;
  logic [3:0]  dm_be;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign dm_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

  core_imem #(.WORDS(IMEM_WORDS), .AW(IAW)) instr_memory (
    .addr  (pc_q[IAW+1:2]),
    .rdata (instr)
  );

  // Reset suppresses any store issued in the same cycle.
  core_dmem #(.WORDS(DMEM_WORDS), .AW(DAW)) data_memory (
    .clk   (clk),
    .we    (dm_we && reset),
    .be    (dm_be),
    .addr  (dm_addr[DAW+1:2]),
    .wdata (dm_wdata),
    .rdata (dm_rdata)
  );

  core_regfile regfile (
    .clk    (clk),
    .resetn (reset),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val),
    .we     (rf_we),
    .waddr  (rd),
    .wdata  (rf_wdata)
  );

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] op, input logic alt);
    logic [31:0] r;
    case (op)
      3'b000:  r = alt ? (a - b) : (a + b);
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'b0, $signed(a) < $signed(b)};
      3'b011:  r = {31'b0, a < b};
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  logic [31:0] ld_byte;
  logic [15:0] ld_half;
  logic        br_taken;

  assign ld_byte = dm_rdata >> {dm_addr[1:0], 3'b000};
  assign ld_half = dm_addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];

  always_comb begin
    case (f3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val < rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_d     = pc_q + 32'd4;
    halted_d = halted_q;
    rf_we    = 1'b0;
    rf_wdata = '0;
    dm_we    = 1'b0;
    dm_be    = 4'b0000;
    dm_wdata = '0;
    case (opcode)
      OP_LUI:   begin rf_we = 1'b1; rf_wdata = imm_u; end
      OP_AUIPC: begin rf_we = 1'b1; rf_wdata = pc_q + imm_u; end
      OP_JAL:   begin rf_we = 1'b1; rf_wdata = pc_q + 32'd4; pc_d = pc_q + imm_j; end
      OP_JALR: begin
        rf_we    = 1'b1;
        rf_wdata = pc_q + 32'd4;
        pc_d     = (rs1_val + imm_i) & ~32'd1;
      end
      OP_BRANCH: if (br_taken) pc_d = pc_q + imm_b;
      OP_LOAD: begin
        rf_we = 1'b1;
        case (f3)
          3'b000:  rf_wdata = {{24{ld_byte[7]}}, ld_byte[7:0]};
          3'b001:  rf_wdata = {{16{ld_half[15]}}, ld_half};
          3'b010:  rf_wdata = dm_rdata;
          3'b100:  rf_wdata = {24'b0, ld_byte[7:0]};
          3'b101:  rf_wdata = {16'b0, ld_half};
          default: rf_we = 1'b0;
        endcase
      end
      OP_STORE: begin
        dm_we = 1'b1;
        case (f3)
          3'b000:  begin dm_be = 4'b0001 << dm_addr[1:0]; dm_wdata = {4{rs2_val[7:0]}}; end
          3'b001:  begin dm_be = dm_addr[1] ? 4'b1100 : 4'b0011; dm_wdata = {2{rs2_val[15:0]}}; end
          3'b010:  begin dm_be = 4'b1111; dm_wdata = rs2_val; end
          default: dm_we = 1'b0;
        endcase
      end
      OP_IMM: begin
        rf_we    = 1'b1;
        rf_wdata = alu(rs1_val, imm_i, f3, (f3 == 3'b101) && instr[30]);
      end
      OP_REG: begin
        rf_we    = 1'b1;
        rf_wdata = alu(rs1_val, rs2_val, f3, instr[30]);
      end
      OP_SYSTEM: begin
        // ECALL and EBREAK differ only in bit 20.
        if (f3 == 3'b000 && instr[31:21] == 11'd0 && instr[19:7] == 13'd0) begin
          halted_d = 1'b1;
          pc_d     = pc_q;
        end
      end
      default: ;
    endcase
    if (halted_q) begin
      pc_d  = pc_q;
      rf_we = 1'b0;
      dm_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

`ifdef CORE_TRACE_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (!halted_q) begin
        $display("cyc=%0d pc=%08h instr=%08h rd=x%0d wdata=%08h%s", cyc_q, pc_q, instr,
                 rf_we ? rd : 5'd0, rf_we ? rf_wdata : 32'd0,
                 dm_we ? $sformatf(" st[%08h]=%08h be=%b", dm_addr, dm_wdata, dm_be) : "");
        if (halted_d) $display("HALT");
      end
    end
  end
`endif
endmodule

// File: tb/tb_core_top.sv
// tb/tb_core_top.sv - directed program tests for core_top
module tb_core_top;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;

  core_top #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int r1, input int f3, input int rd, input logic [6:0] op);
    logic [31:0] v, a, b, c, d;
    v = imm; a = r1; b = f3; c = rd; d = 0;
    return {v[11:0], a[4:0], b[2:0], c[4:0], op} | d;
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int r2, input int r1, input int f3, input int rd);
    logic [31:0] s, a, b, c, e;
    s = f7; a = r2; b = r1; c = f3; e = rd;
    return {s[6:0], a[4:0], b[4:0], c[2:0], e[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int r2, input int r1, input int f3);
    logic [31:0] v, a, b, c;
    v = imm; a = r2; b = r1; c = f3;
    return {v[11:5], a[4:0], b[4:0], c[2:0], v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int r2, input int r1, input int f3);
    logic [31:0] v, a, b, c;
    v = imm; a = r2; b = r1; c = f3;
    return {v[12], v[10:5], a[4:0], b[4:0], c[2:0], v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] v, c;
    v = imm; c = rd;
    return {v[20], v[10:1], v[11], v[19:12], c[4:0], 7'b1101111};
  endfunction

  function automatic logic [31:0] addi(input int rd, input int r1, input int imm);
    return enc_i(imm, r1, 0, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] load(input int f3, input int rd, input int r1, input int imm);
    return enc_i(imm, r1, f3, rd, 7'b0000011);
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) dut.instr_memory.mem[i] = 32'h0000_0013;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge: exactly one rising edge sees reset low.
  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    clear_imem();
    // ALU + x0
    dut.instr_memory.mem[0] = addi(1, 0, 5);
    dut.instr_memory.mem[1] = addi(2, 1, -3);
    dut.instr_memory.mem[2] = enc_r(7'h20, 1, 2, 0, 3);
    dut.instr_memory.mem[3] = addi(0, 0, 7);
    run(2);
    reset = 1'b1;
    check("rst_pc", dut.pc, 32'h0);
    check("rst_halted", {31'b0, dut.halted}, 32'h0);
    check("rst_x5", dut.regfile.regs[5], 32'h0);
    run(3);
    check("alu_x1", dut.regfile.regs[1], 32'd5);
    check("alu_x2", dut.regfile.regs[2], 32'd2);
    check("alu_x3", dut.regfile.regs[3], 32'hFFFF_FFFD);
    run(1);
    check("alu_x0", dut.regfile.regs[0], 32'h0);

    // loads
    clear_imem();
    dut.data_memory.mem[100] = 32'h6865_6c6c;
    dut.data_memory.mem[101] = 32'h6f20_776f;
    dut.data_memory.mem[102] = 32'h0000_80F0;
    dut.instr_memory.mem[0] = addi(1, 0, 400);
    dut.instr_memory.mem[1] = load(2, 2, 1, 0);
    dut.instr_memory.mem[2] = load(4, 3, 1, 3);
    dut.instr_memory.mem[3] = load(0, 4, 1, 0);
    dut.instr_memory.mem[4] = enc_r(0, 4, 4, 0, 10);
    dut.instr_memory.mem[5] = load(1, 5, 1, 2);
    dut.instr_memory.mem[6] = load(0, 6, 1, 5);
    dut.instr_memory.mem[7] = load(0, 7, 1, 8);
    dut.instr_memory.mem[8] = load(5, 8, 1, 8);
    dut.instr_memory.mem[9] = load(1, 9, 1, 8);
    pulse_reset();
    run(10);
    check("lw", dut.regfile.regs[2], 32'h6865_6c6c);
    check("lbu_403", dut.regfile.regs[3], 32'h68);
    check("lb_400", dut.regfile.regs[4], 32'h6c);
    check("load_use", dut.regfile.regs[10], 32'hd8);
    check("lh_402", dut.regfile.regs[5], 32'h6865);
    check("lb_405", dut.regfile.regs[6], 32'h77);
    check("lb_sext", dut.regfile.regs[7], 32'hFFFF_FFF0);
    check("lhu_zext", dut.regfile.regs[8], 32'h0000_80F0);
    check("lh_sext", dut.regfile.regs[9], 32'hFFFF_80F0);

    // stores
    clear_imem();
    dut.data_memory.mem[120] = 32'h1122_3344;
    dut.data_memory.mem[121] = 32'h0;
    dut.data_memory.mem[122] = 32'h1122_3344;
    dut.instr_memory.mem[0] = addi(1, 0, 481);
    dut.instr_memory.mem[1] = addi(2, 0, 170);
    dut.instr_memory.mem[2] = enc_s(0, 2, 1, 0);
    dut.instr_memory.mem[3] = {20'hDEADC, 5'd3, 7'b0110111};
    dut.instr_memory.mem[4] = addi(3, 3, -273);
    dut.instr_memory.mem[5] = addi(4, 0, 484);
    dut.instr_memory.mem[6] = enc_s(0, 3, 4, 2);
    dut.instr_memory.mem[7] = addi(5, 0, 490);
    dut.instr_memory.mem[8] = enc_s(0, 3, 5, 1);
    pulse_reset();
    run(9);
    check("sb", dut.data_memory.mem[120], 32'h1122_AA44);
    check("sw", dut.data_memory.mem[121], 32'hDEAD_BEEF);
    check("sh_hi", dut.data_memory.mem[122], 32'hBEEF_3344);

    // control flow
    clear_imem();
    dut.instr_memory.mem[0]  = addi(1, 0, -1);
    dut.instr_memory.mem[1]  = addi(2, 0, 1);
    dut.instr_memory.mem[2]  = enc_b(8, 0, 0, 0);
    dut.instr_memory.mem[3]  = addi(10, 0, 1);
    dut.instr_memory.mem[4]  = enc_b(8, 2, 1, 6);
    dut.instr_memory.mem[5]  = addi(11, 0, 2);
    dut.instr_memory.mem[6]  = enc_b(8, 2, 1, 4);
    dut.instr_memory.mem[7]  = addi(12, 0, 3);
    dut.instr_memory.mem[8]  = enc_j(8, 5);
    dut.instr_memory.mem[9]  = addi(13, 0, 4);
    dut.instr_memory.mem[10] = addi(6, 0, 53);
    dut.instr_memory.mem[11] = enc_i(0, 6, 0, 7, 7'b1100111);
    dut.instr_memory.mem[12] = addi(14, 0, 5);
    dut.instr_memory.mem[13] = addi(15, 0, 6);
    pulse_reset();
    run(10);
    check("cf_pc", dut.pc, 32'h38);
    check("beq_skip", dut.regfile.regs[10], 32'h0);
    check("bltu_nt", dut.regfile.regs[11], 32'h2);
    check("blt_t", dut.regfile.regs[12], 32'h0);
    check("jal_link", dut.regfile.regs[5], 32'h24);
    check("jal_skip", dut.regfile.regs[13], 32'h0);
    check("jalr_link", dut.regfile.regs[7], 32'h30);
    check("jalr_skip", dut.regfile.regs[14], 32'h0);
    check("jalr_tgt", dut.regfile.regs[15], 32'h6);

    // halt then reset
    clear_imem();
    dut.data_memory.mem[0] = 32'h6a09_e667;
    dut.instr_memory.mem[0] = addi(1, 0, 1);
    dut.instr_memory.mem[1] = addi(2, 0, 2);
    dut.instr_memory.mem[2] = addi(3, 0, 3);
    dut.instr_memory.mem[3] = addi(4, 0, 4);
    dut.instr_memory.mem[4] = 32'h0000_0073;
    dut.instr_memory.mem[5] = addi(5, 0, 9);
    dut.instr_memory.mem[6] = enc_s(0, 1, 0, 2);
    pulse_reset();
    run(5);
    check("halt_flag", {31'b0, dut.halted}, 32'h1);
    run(5);
    check("halt_pc", dut.pc, 32'h10);
    check("halt_nowr", dut.regfile.regs[5], 32'h0);
    check("halt_nost", dut.data_memory.mem[0], 32'h6a09_e667);
    pulse_reset();
    check("hr_pc", dut.pc, 32'h0);
    check("hr_halted", {31'b0, dut.halted}, 32'h0);
    check("hr_x4", dut.regfile.regs[4], 32'h0);
    check("hr_mem", dut.data_memory.mem[0], 32'h6a09_e667);

    // reset mid-loop with store in flight
    clear_imem();
    dut.data_memory.mem[50] = 32'h1234_5678;
    dut.instr_memory.mem[0] = addi(1, 0, 200);
    dut.instr_memory.mem[1] = addi(2, 2, 1);
    dut.instr_memory.mem[2] = enc_s(0, 2, 1, 2);
    dut.instr_memory.mem[3] = enc_j(-8, 0);
    pulse_reset();
    run(2);
    check("loop_pc", dut.pc, 32'h8);
    pulse_reset();
    check("mid_nost", dut.data_memory.mem[50], 32'h1234_5678);
    check("mid_pc", dut.pc, 32'h0);
    check("mid_x2", dut.regfile.regs[2], 32'h0);
    run(3);
    check("loop_st", dut.data_memory.mem[50], 32'h1);
    run(3);
    check("loop_back", dut.data_memory.mem[50], 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
